gtgen: RTL and testbench

- Generates the 22-bit global time counter `gt` in the external 125 MHz clock domain. This is the counter that downstream per-channel latches sample on trigger.
- Resynchronises `gt` from a serial sync frame arriving on a single line from the master timing source.
- Reports sync status, counter wrap, time slips and frame parity errors to the control logic.

---
 rtl/gtgen.sv | 124 ++++++++++++
 tb/tb_gtgen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/gtgen.sv
// Global time counter for the extclk domain, resynchronised from a serial sync frame
// (start bit, 22 data bits MSB first, even parity) received on gtsync.
module gtgen #(
    parameter int unsigned LOAD_DELAY    = 23,
    parameter int unsigned TIMEOUT_WRAPS = 4
) (
    input  logic        extclk,
    input  logic        reset,
    input  logic        gtsync,
    output logic [21:0] gt,
    output logic        wrap,
    output logic        synced,
    output logic        slip,
    output logic        perr
);

    localparam logic [21:0] LoadDelay    = 22'(LOAD_DELAY);
    localparam logic [3:0]  TimeoutWraps = 4'(TIMEOUT_WRAPS);

    typedef enum logic [1:0] {StIdle, StData, StParity} state_e;

    state_e      state_q, state_d;
    logic [21:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [21:0] gt_q, gt_d;
    logic        wrap_q, wrap_d;
    logic        synced_q, synced_d;
    logic        slip_q, slip_d;
    logic        perr_q, perr_d;

    logic        load;
    logic        bad;
    logic [21:0] gt_inc;
    logic [21:0] load_val;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        bad     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gtsync) begin
                    state_d = StData;
                    cnt_d   = 5'd0;
                end
            end
            StData: begin
                shift_d = {shift_q[20:0], gtsync};
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd21) begin
                    state_d = StParity;
                end
            end
            StParity: begin
                state_d = StIdle;
                if (^{shift_q, gtsync}) begin
                    bad = 1'b1;
                end else begin
                    load = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gt_inc   = gt_q + 22'd1;
        load_val = shift_q + LoadDelay;
        gt_d     = load ? load_val : gt_inc;
        // A load landing on the would-be wrap edge suppresses the wrap pulse.
        wrap_d   = !load && (gt_q == 22'h3FFFFF);
        slip_d   = load && (load_val != gt_inc);
        perr_d   = bad;
        wcnt_d   = wcnt_q;
        synced_d = synced_q;
        if (load) begin
            wcnt_d   = 4'd0;
            synced_d = 1'b1;
        end else begin
            if (wrap_d && (wcnt_q != 4'hF)) begin
                wcnt_d = wcnt_q + 4'd1;
            end
            if (bad) begin
                synced_d = 1'b0;
            end else if (wrap_d && synced_q && (wcnt_d == TimeoutWraps)) begin
                synced_d = 1'b0;
            end
        end
    end

    always_ff @(posedge extclk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            gt_q     <= '0;
            wrap_q   <= 1'b0;
            synced_q <= 1'b0;
            slip_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
            gt_q     <= gt_d;
            wrap_q   <= wrap_d;
            synced_q <= synced_d;
            slip_q   <= slip_d;
            perr_q   <= perr_d;
        end
    end

    assign gt     = gt_q;
    assign wrap   = wrap_q;
    assign synced = synced_q;
    assign slip   = slip_q;
    assign perr   = perr_q;

endmodule

// File: tb/tb_gtgen.sv
// Bench for gtgen: frame table, hand-built corner sequences and random gtsync traffic,
// all checked every cycle against a queue-based frame model.
module tb_gtgen;

    localparam int unsigned LD = 23;
    localparam int unsigned TW = 1;
    localparam int unsigned M  = 32'h400000;

    logic        extclk = 1'b0;
    logic        reset  = 1'b1;
    logic        gtsync = 1'b0;
    logic [21:0] gt;
    logic        wrap, synced, slip, perr;

    gtgen #(.LOAD_DELAY(LD), .TIMEOUT_WRAPS(TW)) dut (
        .extclk(extclk),
        .reset (reset),
        .gtsync(gtsync),
        .gt    (gt),
        .wrap  (wrap),
        .synced(synced),
        .slip  (slip),
        .perr  (perr)
    );

    always #5 extclk = ~extclk;

    int n_err = 0;
    int n_chk = 0;

    // Reference model state
    int unsigned m_gt;
    bit          m_wrap, m_synced, m_slip, m_perr, m_busy;
    int unsigned m_wcnt;
    bit          m_bits[$];

    typedef struct {
        logic [21:0] word;
        bit          flip;
        logic [21:0] exp_gt;
        bit          exp_perr;
        bit          exp_synced;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gt = 0; m_wrap = 0; m_synced = 0; m_slip = 0; m_perr = 0;
        m_wcnt = 0; m_busy = 0;
        m_bits.delete();
    endtask

    task automatic model_step(input bit s);
        bit          ld;
        bit          bad;
        bit          p;
        int unsigned word;
        int unsigned nxt;
        ld = 0; bad = 0; p = 0; word = 0;
        if (m_busy) begin
            m_bits.push_back(s);
            if (m_bits.size() == 23) begin
                for (int i = 0; i < 23; i++) p ^= m_bits[i];
                for (int i = 0; i < 22; i++) word = (word << 1) | int'(m_bits[i]);
                if (p) bad = 1; else ld = 1;
                m_busy = 0;
            end
        end else if (s) begin
            m_busy = 1;
            m_bits.delete();
        end
        nxt    = (m_gt + 1) % M;
        m_wrap = !ld && (m_gt == M - 1);
        m_slip = ld && (((word + LD) % M) != nxt);
        m_perr = bad;
        m_gt   = ld ? (word + LD) % M : nxt;
        if (ld) begin
            m_wcnt   = 0;
            m_synced = 1;
        end else begin
            if (m_wrap && m_wcnt < 15) m_wcnt++;
            if (bad) m_synced = 0;
            else if (m_wrap && m_synced && m_wcnt == TW) m_synced = 0;
        end
    endtask

    task automatic check_all();
        check("gt", 32'(gt), m_gt);
        check("wrap", 32'(wrap), 32'(m_wrap));
        check("synced", 32'(synced), 32'(m_synced));
        check("slip", 32'(slip), 32'(m_slip));
        check("perr", 32'(perr), 32'(m_perr));
    endtask

    task automatic step(input bit s);
        gtsync = s;
        @(posedge extclk);
        #1;
        model_step(s);
        check_all();
    endtask

    task automatic send_frame(input logic [21:0] w, input bit flip);
        step(1'b1);
        for (int i = 21; i >= 0; i--) step(w[i]);
        step((^w) ^ flip);
    endtask

    task automatic do_reset();
        @(negedge extclk);
        gtsync = 1'b0;
        reset  = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge extclk);
        @(negedge extclk);
        reset = 1'b0;
    endtask

    initial begin
        int          wraps;
        int unsigned g;
        logic [21:0] w;

        tbl[0] = '{22'h012345, 1'b0, 22'h01235C, 1'b0, 1'b1};
        tbl[1] = '{22'h012345, 1'b1, 22'h000000, 1'b1, 1'b0};
        tbl[2] = '{22'h000000, 1'b0, 22'h000017, 1'b0, 1'b1};
        tbl[3] = '{22'h3FFFFF, 1'b0, 22'h000016, 1'b0, 1'b1};
        tbl[4] = '{22'h2AAAAA, 1'b1, 22'h000000, 1'b1, 1'b0};
        tbl[5] = '{22'h155555, 1'b0, 22'h15556C, 1'b0, 1'b1};

        model_reset();
        #2;
        check_all();
        do_reset();

        // Free-running count from reset
        for (int i = 0; i < 100; i++) begin
            step(1'b0);
            check("count", 32'(gt), 32'(i + 1));
        end

        // Frame table
        for (int t = 0; t < 6; t++) begin
            repeat (3) step(1'b0);
            send_frame(tbl[t].word, tbl[t].flip);
            if (!tbl[t].flip) check("tbl_gt", 32'(gt), 32'(tbl[t].exp_gt));
            check("tbl_perr", 32'(perr), 32'(tbl[t].exp_perr));
            check("tbl_synced", 32'(synced), 32'(tbl[t].exp_synced));
        end
        step(1'b0);
        check("post_load_inc", 32'(gt), 32'h15556D);
        check("perr_one_cycle", 32'(perr), 0);

        // Frames consistent with the running count never slip
        for (int k = 0; k < 2; k++) begin
            repeat (5) step(1'b0);
            g = m_gt;
            w = 22'((g + 1) % M);
            send_frame(w, 1'b0);
            check("consistent_slip", 32'(slip), 0);
            check("consistent_gt", 32'(gt), (g + 24) % M);
        end

        // Wrap pulse and timeout
        send_frame(22'h3FFFD9, 1'b0);
        check("pre_wrap_gt", 32'(gt), 32'h3FFFF0);
        wraps = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0);
            wraps += int'(wrap);
        end
        check("wrap_count", 32'(wraps), 1);
        check("wrap_gt", 32'(gt), 0);
        check("timeout_synced", 32'(synced), 0);

        // Load of 0 exactly on the would-be wrap edge
        send_frame(22'h3FFFD1, 1'b0);
        check("pre_coinc_gt", 32'(gt), 32'h3FFFE8);
        send_frame(22'h3FFFE9, 1'b0);
        check("coinc_gt", 32'(gt), 0);
        check("coinc_wrap", 32'(wrap), 0);
        check("coinc_slip", 32'(slip), 0);
        check("coinc_synced", 32'(synced), 1);

        // Reset in the middle of a frame
        w = 22'h0ABCDE;
        step(1'b1);
        for (int i = 21; i > 11; i--) step(w[i]);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge extclk);
        @(negedge extclk);
        reset = 1'b0;
        repeat (2) step(1'b0);
        send_frame(22'h012345, 1'b0);
        check("after_reset_gt", 32'(gt), 32'h01235C);
        check("after_reset_slip", 32'(slip), 1);
        check("after_reset_synced", 32'(synced), 1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                send_frame(22'($urandom), $urandom_range(0, 3) == 0);
            end else begin
                step($urandom_range(0, 15) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
